// File: rtl/lab3_cache_mem_responder_pkg.sv
// rtl/lab3_cache_mem_responder_pkg.sv - shared 4B memory request/response message types
package lab3_cache_mem_responder_pkg;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  function automatic logic mem_is_write(input logic [2:0] t);
    return (t == MEM_TYPE_WRITE) || (t == MEM_TYPE_INIT);
  endfunction

endpackage

// File: rtl/lab3_cache_mem_responder_resp_queue.sv
// rtl/lab3_cache_mem_responder_resp_queue.sv - in-order response FIFO with per-entry latency countdown
module lab3_cache_resp_queue
  import lab3_cache_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val_i,
  input  mem_resp_4B_t enq_msg_i,
  output logic         full_o,
  input  logic         deq_i,
  output logic         head_val_o,
  output mem_resp_4B_t head_msg_o
);

  localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CNT_W = PTR_W + 1;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  mem_resp_4B_t     msg_q [DEPTH];
  logic [3:0]       dly_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             enq;
  logic             deq;
  logic             empty;

  assign empty      = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign head_val_o = !empty && (dly_q[rd_ptr_q] == 4'd0);
  assign head_msg_o = msg_q[rd_ptr_q];
  // No bypass: a full queue refuses the request even if the head leaves this cycle.
  assign enq        = enq_val_i && !full_o;
  assign deq        = deq_i && head_val_o;

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        msg_q[i] <= '0;
        dly_q[i] <= '0;
      end
    end else begin
      // Every entry counts down independently, so stalled-behind entries mature meanwhile.
      for (int i = 0; i < DEPTH; i++) begin
        if (dly_q[i] != 4'd0) dly_q[i] <= dly_q[i] - 4'd1;
      end
      if (enq) begin
        msg_q[wr_ptr_q] <= enq_msg_i;
        dly_q[wr_ptr_q] <= LAT;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lab3_cache_mem_responder.sv
// rtl/lab3_cache_mem_responder.sv - word-array memory responder; LAB3_CACHE_MEM_RESPONDER_STALL_EN adds LFSR stalls
module lab3_cache_mem_responder
  import lab3_cache_mem_responder_pkg::*;
#(
  parameter int NUM_WORDS   = 256,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  mem_req_4B_t  memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output mem_resp_4B_t memresp_msg
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  logic [31:0]      mem_q [NUM_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic             req_fire;
  logic             resp_fire;
  logic             q_full;
  logic             q_head_val;
  logic             stall_req;
  logic             stall_resp;
  mem_resp_4B_t     resp_d;
  logic             unused_bits;

  assign word_idx    = memreq_msg.addr[2 +: IDX_W];
  assign memreq_rdy  = !q_full && !stall_req;
  assign req_fire    = memreq_val && memreq_rdy;
  assign memresp_val = q_head_val && !stall_resp;
  assign resp_fire   = memresp_val && memresp_rdy;
  assign unused_bits = ^{memreq_msg.addr, memreq_msg.len};

  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (req_fire && mem_is_write(memreq_msg.type_)) begin
      mem_q[word_idx] <= memreq_msg.data;
    end
  end

  always_comb begin
    resp_d        = '0;
    resp_d.type_  = memreq_msg.type_;
    resp_d.opaque = memreq_msg.opaque;
    resp_d.test   = 2'b00;
    resp_d.len    = 2'b00;
    resp_d.data   = (memreq_msg.type_ == MEM_TYPE_READ) ? mem_q[word_idx] : 32'h0;
  end

`ifdef LAB3_CACHE_MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // x^8+x^6+x^5+x^4+1 taps map to bits 7,5,4,3.
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall_req  = lfsr_q[0];
  assign stall_resp = lfsr_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign stall_req  = 1'b0;
  assign stall_resp = 1'b0;
`endif

  lab3_cache_resp_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_queue (
    .clk        (clk),
    .reset      (reset),
    .enq_val_i  (req_fire),
    .enq_msg_i  (resp_d),
    .full_o     (q_full),
    .deq_i      (resp_fire),
    .head_val_o (q_head_val),
    .head_msg_o (memresp_msg)
  );

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// tb/tb_lab3_cache_mem_responder.sv - directed self-checking bench for lab3_cache_mem_responder
module tb_lab3_cache_mem_responder;
  import lab3_cache_mem_responder_pkg::*;

  logic         clk;
  logic         reset;
  logic         memreq_val;
  logic         memreq_rdy;
  mem_req_4B_t  memreq_msg;
  logic         memresp_val;
  logic         memresp_rdy;
  mem_resp_4B_t memresp_msg;

  int checks;
  int errors;

  lab3_cache_mem_responder #(
    .NUM_WORDS   (256),
    .LATENCY     (2),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic mem_resp_4B_t rsp(input logic [2:0] t, input logic [7:0] op, input logic [31:0] d);
    mem_resp_4B_t r;
    r.type_  = t;
    r.opaque = op;
    r.test   = 2'b00;
    r.len    = 2'b00;
    r.data   = d;
    return r;
  endfunction

  task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d, input logic [7:0] op);
    memreq_msg.type_  = t;
    memreq_msg.opaque = op;
    memreq_msg.addr   = a;
    memreq_msg.len    = 2'b00;
    memreq_msg.data   = d;
    memreq_val        = 1'b1;
  endtask

  task automatic send(input string tag, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d, input logic [7:0] op);
    drive(t, a, d, op);
    chk(tag, 64'(memreq_rdy), 64'd1);
    step();
    memreq_val = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input mem_resp_4B_t exp);
    for (int c = 0; c < 20 && !memresp_val; c++) step();
    chk(tag, 64'(memresp_val), 64'd1);
    chk(tag, 64'(memresp_msg), 64'(exp));
    memresp_rdy = 1'b1;
    step();
    memresp_rdy = 1'b0;
  endtask

  initial begin
    int acc;
    int nxt;
    logic thru_ok;
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    memreq_val  = 1'b0;
    memresp_rdy = 1'b0;
    memreq_msg  = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_req_rdy", 64'(memreq_rdy), 64'd1);
    chk("rst_resp_val", 64'(memresp_val), 64'd0);
    chk("rst_resp_msg", 64'(memresp_msg), 64'd0);

    // Latency: accepted at edge ending cycle C, valid first in C+3.
    send("wr40_rdy", MEM_TYPE_WRITE, 32'h0000_0040, 32'hDEAD_BEEF, 8'h11);
    chk("lat_c1", 64'(memresp_val), 64'd0);
    step();
    chk("lat_c2", 64'(memresp_val), 64'd0);
    step();
    chk("lat_c3", 64'(memresp_val), 64'd1);
    expect_resp("wr40_resp", rsp(3'd1, 8'h11, 32'h0));

    send("rd40_rdy", MEM_TYPE_READ, 32'h0000_0040, 32'h0, 8'h12);
    expect_resp("rd40_resp", rsp(3'd0, 8'h12, 32'hDEAD_BEEF));

    send("init400_rdy", MEM_TYPE_INIT, 32'h0000_0400, 32'h1234_5678, 8'h20);
    expect_resp("init400_resp", rsp(3'd2, 8'h20, 32'h0));
    send("rd0_rdy", MEM_TYPE_READ, 32'h0000_0000, 32'h0, 8'h21);
    expect_resp("rd0_wrap", rsp(3'd0, 8'h21, 32'h1234_5678));

    // Back-to-back write then read of the same word.
    drive(MEM_TYPE_WRITE, 32'h0000_0044, 32'hCAFE_F00D, 8'h22);
    step();
    drive(MEM_TYPE_READ, 32'h0000_0044, 32'h0, 8'h23);
    step();
    memreq_val = 1'b0;
    expect_resp("raw_wr", rsp(3'd1, 8'h22, 32'h0));
    expect_resp("raw_rd", rsp(3'd0, 8'h23, 32'hCAFE_F00D));

    send("other_rdy", 3'd5, 32'h0000_0044, 32'hFFFF_FFFF, 8'h30);
    expect_resp("other_resp", rsp(3'd5, 8'h30, 32'h0));
    send("rd44_rdy", MEM_TYPE_READ, 32'h0000_0044, 32'h0, 8'h31);
    expect_resp("other_nowrite", rsp(3'd0, 8'h31, 32'hCAFE_F00D));

    // Fill one line at full throughput with the response side always ready.
    memresp_rdy = 1'b1;
    thru_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(MEM_TYPE_WRITE, 32'h80 + 32'(4 * i), 32'h1000 + 32'(i), 8'h60);
      if (!memreq_rdy) thru_ok = 1'b0;
      step();
    end
    memreq_val = 1'b0;
    repeat (5) step();
    memresp_rdy = 1'b0;
    chk("thru_rdy_held", 64'(thru_ok), 64'd1);
    chk("thru_drained", 64'(memresp_val), 64'd0);

    // Backpressure: 16 line reads against a stalled response port.
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(MEM_TYPE_READ, 32'h80 + 32'(4 * acc), 32'h0, 8'(acc));
      if (memreq_rdy) acc++;
      step();
    end
    memreq_val = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd4);
    chk("bp_rdy_low", 64'(memreq_rdy), 64'd0);
    chk("bp_head", 64'(memresp_msg), 64'(rsp(3'd0, 8'h00, 32'h1000)));
    memresp_rdy = 1'b1;
    nxt = 0;
    for (int c = 0; c < 100 && nxt < 16; c++) begin
      if (acc < 16) drive(MEM_TYPE_READ, 32'h80 + 32'(4 * acc), 32'h0, 8'(acc));
      else          memreq_val = 1'b0;
      if (memreq_val && memreq_rdy) acc++;
      if (memresp_val) begin
        chk("bp_resp", 64'(memresp_msg), 64'(rsp(3'd0, 8'(nxt), 32'h1000 + 32'(nxt))));
        nxt++;
      end
      step();
    end
    memreq_val  = 1'b0;
    memresp_rdy = 1'b0;
    chk("bp_all", 64'(nxt), 64'd16);

    // Steady enqueue+dequeue at occupancy 3.
    for (int i = 0; i < 3; i++) send("occ_fill", MEM_TYPE_READ, 32'h80, 32'h0, 8'(8'h40 + i));
    repeat (3) step();
    for (int k = 0; k < 10; k++) begin
      drive(MEM_TYPE_READ, 32'h80, 32'h0, 8'(8'h43 + k));
      memresp_rdy = 1'b1;
      chk("occ_steady", 64'({memreq_rdy, memresp_val, memresp_msg.opaque}),
          64'({1'b1, 1'b1, 8'(8'h40 + k)}));
      step();
    end
    memreq_val  = 1'b0;
    memresp_rdy = 1'b0;
    send("occ_one_slot", MEM_TYPE_READ, 32'h80, 32'h0, 8'h4D);
    chk("occ_now_full", 64'(memreq_rdy), 64'd0);
    expect_resp("occ_head", rsp(3'd0, 8'h4A, 32'h1000));

    // Reset with three responses pending.
    chk("pre_rst_pending", 64'(memresp_val), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_val", 64'(memresp_val), 64'd0);
    chk("mid_rst_rdy", 64'(memreq_rdy), 64'd1);
    chk("mid_rst_msg", 64'(memresp_msg), 64'd0);
    send("post_rst_rdy", MEM_TYPE_READ, 32'h0000_0040, 32'h0, 8'h50);
    expect_resp("post_rst_rd40", rsp(3'd0, 8'h50, 32'hDEAD_BEEF));
    send("post_rst_rdy2", MEM_TYPE_READ, 32'h0000_0400, 32'h0, 8'h51);
    expect_resp("post_rst_rd400", rsp(3'd0, 8'h51, 32'h1234_5678));
    step();
    chk("final_idle", 64'({memresp_val, memreq_rdy}), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab3_cache_mem_responder.md
# lab3_cache_mem_responder

Memory-side responder for the 4B memory request/response protocol issued by the cache's batch sender and consumed by its batch receiver. Accepts one `mem_req_4B_t` per cycle and performs the word read or write on an internal word array. Returns one `mem_resp_4B_t` per request, in order, after a fixed programmable latency through a bounded response queue. Serves as the cache's backing memory in unit and integration benches, and as the refill/evict target for 16-word line transfers.

## Interface

Parameters:
- `NUM_WORDS`, 256: words of storage; power of two, at least 16.
- `LATENCY`, 2: extra cycles between request accept and earliest response valid; range 0..15.
- `QUEUE_DEPTH`, 4: maximum outstanding requests (in flight plus queued); power of two, at least 2.

Ports:
- `clk` in 1: clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `memreq_val` in 1: request valid.
- `memreq_rdy` out 1: request ready.
- `memreq_msg` in 77: `mem_req_4B_t` {type_, opaque, addr, len, data}.
- `memresp_val` out 1: response valid.
- `memresp_rdy` in 1: response ready.
- `memresp_msg` out 47: `mem_resp_4B_t` {type_, opaque, test, len, data}.

## Operation

Handshake:
- A request is accepted in any cycle where `memreq_val && memreq_rdy`.
- A response is consumed in any cycle where `memresp_val && memresp_rdy`.

Addressing:
- Word index = `addr[2 +: $clog2(NUM_WORDS)]`.
- Upper address bits are ignored, so addresses wrap modulo `NUM_WORDS*4` bytes.
- `addr[1:0]` and `len` are ignored; every access is a full 32-bit word.

Request types:
- READ (3'd0): array word is sampled at the accept edge.
- WRITE (3'd1): `data` is written at the accept edge.
- INIT (3'd2): behaves as WRITE.
- Any other type: no array access; the response carries `data`=0.

Ordering:
- Array accesses apply in accept order.
- A READ accepted one cycle after a WRITE to the same word returns the new data.

Response fields:
- `type_`: echo of the request.
- `opaque`: echo of the request.
- `test`: 2'b0.
- `len`: 2'b0.
- `data`: the read word for READ, 0 for all other types.

Queue:
- FIFO of `QUEUE_DEPTH` entries. Each entry holds the response message plus a 4-bit countdown.
- The countdown loads `LATENCY` on enqueue and decrements each cycle while nonzero.
- `memresp_val` = queue not empty and head countdown == 0.
- `memreq_rdy` = occupancy < `QUEUE_DEPTH`. There is no same-cycle enqueue/dequeue bypass when full.
- Enqueue and dequeue in the same cycle (not full) leave occupancy unchanged.

## Timing

- Latency: a request accepted in cycle C produces a response with earliest `memresp_val` in cycle C+1+LATENCY.
- A held `memresp_rdy`=0 stalls the head. Younger entries keep counting down. Once the head is consumed, a younger entry whose countdown is already 0 is valid in the next cycle.
- Throughput: one request and one response per cycle at steady state when `QUEUE_DEPTH` > LATENCY+1.
- Outputs are registered. `memresp_msg` is stable while `memresp_val` && !`memresp_rdy`.

Reset (asynchronous, at any point):
- Empties the queue: `memreq_rdy`=1 and `memresp_val`=0 from the first cycle after reset deasserts.
- `memresp_msg` = 0.
- In-flight responses are discarded.
- Array contents are not reset.

## Configuration

- `LAB3_CACHE_MEM_RESPONDER_STALL_EN` defined: adds an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advancing every cycle.
  - `lfsr[0]`=1 forces `memreq_rdy` low.
  - `lfsr[1]`=1 forces `memresp_val` low.
  - All ordering, data and latency lower bounds still hold.
- Undefined: no LFSR and no injected stalls; behaviour is exactly as in Operation and Timing.

## Structure

- Type encodings (READ/WRITE/INIT) and the `mem_req_4B_t` / `mem_resp_4B_t` typedefs come from the shared memory-message package. No local redefinition.
- Sub-module `lab3_cache_resp_queue` contains the counted FIFO with per-entry latency countdowns and full/empty logic.
- The top level holds the word array, request decode and response formatting.

## Test plan

- Reset, LATENCY=2: WRITE addr 0x0000_0040 data 0xDEAD_BEEF opaque 0x11 accepted in cycle 5 -> response valid in cycle 8 with type 1, opaque 0x11, data 0.
- Then READ addr 0x0000_0040 opaque 0x12 -> response data 0xDEAD_BEEF, opaque 0x12.
- Aliasing, NUM_WORDS=256: INIT addr 0x0000_0400 data 0x1234_5678, then READ addr 0x0000_0000 -> data 0x1234_5678 (wrap).
- Backpressure: 16 back-to-back READs (one cache line) with `memresp_rdy`=0 -> `memreq_rdy` falls after 4 accepts. Release rdy -> all 16 responses in order, opaques 0..15.
- Simultaneous accept and consume at occupancy 3 for 10 cycles -> occupancy stays 3, `memreq_rdy` stays 1, no response lost.
- Assert reset for one cycle with 3 responses pending -> `memresp_val`=0 and `memreq_rdy`=1 next cycle. A READ of a previously written word still returns the old data.
